// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: operand forwarding, load-use bubbles and memory-wait freeze for the 5-stage core
// Optional build macro WB_BYPASS_EN adds a writeback bypass register reported as fwd_sel 2'b11
module hazard_fwd_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int WAIT_CNT_W = 4,
  parameter int PERF_CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0]         ex_rd,
  input  logic                          ex_reg_write,
  input  logic                          ex_mem_read,
  input  logic [REG_ADDR_W-1:0]         mem_rd,
  input  logic                          mem_reg_write,
  input  logic                          mem_busy,
  input  logic [REG_ADDR_W-1:0]         wb_rd,
  input  logic                          wb_reg_write,
  output logic [2*NUM_SRC-1:0]          fwd_sel,
  output logic                          stall_pc,
  output logic                          stall_if_id,
  output logic                          bubble_id_ex,
  output logic                          stall_ex_mem,
  output logic                          timeout_err,
  output logic [PERF_CNT_W-1:0]         lu_stall_cnt
);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t                state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  timeout_q, timeout_d;
  logic [PERF_CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic                  lu;
`ifdef WB_BYPASS_EN
  logic [REG_ADDR_W-1:0] bp_rd_q, bp_rd_d;
  logic                  bp_valid_q, bp_valid_d;
`endif
  // per-operand forwarding select, nearest producer wins
  always_comb begin
    fwd_sel = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      fwd_sel[2*j +: 2] =
        (mem_reg_write && mem_rd != '0 && mem_rd == ex_rs[j*REG_ADDR_W +: REG_ADDR_W]) ? 2'b10 :
        (wb_reg_write && wb_rd != '0 && wb_rd == ex_rs[j*REG_ADDR_W +: REG_ADDR_W]) ? 2'b01 :
`ifdef WB_BYPASS_EN
        (bp_valid_q && bp_rd_q == ex_rs[j*REG_ADDR_W +: REG_ADDR_W]) ? 2'b11 :
`endif
        2'b00;
    end
  end
  // load in ID/EX feeding any ID source operand
  always_comb begin
    lu = 1'b0;
    for (int j = 0; j < NUM_SRC; j++)
      lu = lu | (ex_rd == id_rs[j*REG_ADDR_W +: REG_ADDR_W]);
    lu = lu && id_valid && ex_mem_read && ex_reg_write && ex_rd != '0;
  end
  // freeze/bubble control, wait watchdog and perf counter next-state
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    stall_ex_mem = 1'b0;
    if (mem_busy) begin
      state_d      = MEM_WAIT;
      wait_cnt_d   = (state_q == RUN) ? WAIT_CNT_W'(1) : (&wait_cnt_q ? wait_cnt_q : wait_cnt_q + 1'b1);
      stall_pc     = 1'b1;
      stall_if_id  = 1'b1;
      stall_ex_mem = 1'b1;
    end else begin
      state_d      = RUN;
      wait_cnt_d   = '0;
      stall_pc     = lu;
      stall_if_id  = lu;
      bubble_id_ex = lu;
    end
    timeout_d = timeout_q | (mem_busy && &wait_cnt_d);
    lu_cnt_d  = (bubble_id_ex && !(&lu_cnt_q)) ? lu_cnt_q + 1'b1 : lu_cnt_q;
  end
`ifdef WB_BYPASS_EN
  // remember the last retired destination while the back end is moving
  always_comb begin
    bp_valid_d = bp_valid_q | (wb_reg_write && wb_rd != '0 && !stall_ex_mem);
    bp_rd_d    = (wb_reg_write && wb_rd != '0 && !stall_ex_mem) ? wb_rd : bp_rd_q;
  end
  // bypass register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bp_valid_q <= 1'b0;
      bp_rd_q    <= '0;
    end else begin
      bp_valid_q <= bp_valid_d;
      bp_rd_q    <= bp_rd_d;
    end
`endif
  // state, watchdog and counter registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      lu_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      lu_cnt_q   <= lu_cnt_d;
    end
  assign timeout_err  = timeout_q;
  assign lu_stall_cnt = lu_cnt_q;
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: scoreboard bench for hazard_fwd_ctrl (default parameters)
module tb_hazard_fwd_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, ex_reg_write, ex_mem_read, mem_reg_write, mem_busy, wb_reg_write;
  logic [9:0]  id_rs, ex_rs;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic [3:0]  fwd_sel;
  logic        stall_pc, stall_if_id, bubble_id_ex, stall_ex_mem, timeout_err;
  logic [15:0] lu_stall_cnt;
  int          total = 0, bad = 0;
  int          exp_cnt = 0;
  typedef struct {
    string      tag;
    logic [3:0] fwd;
    logic [3:0] ctl;
    logic       to;
    logic [15:0] cnt;
  } exp_t;
  exp_t sb[$];
  exp_t cur;
  hazard_fwd_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .ex_rs(ex_rs),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_busy(mem_busy),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .fwd_sel(fwd_sel),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
    .stall_ex_mem(stall_ex_mem), .timeout_err(timeout_err), .lu_stall_cnt(lu_stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic clear();
    id_valid = 0; ex_reg_write = 0; ex_mem_read = 0; mem_reg_write = 0;
    mem_busy = 0; wb_reg_write = 0; id_rs = '0; ex_rs = '0;
    ex_rd = '0; mem_rd = '0; wb_rd = '0;
  endtask
  task automatic step(string tag, logic [3:0] fwd, logic [3:0] ctl, logic to);
    exp_t e;
    e.tag = tag; e.fwd = fwd; e.ctl = ctl; e.to = to; e.cnt = 16'(exp_cnt);
    sb.push_back(e);
    if (ctl[1]) exp_cnt++;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      chk({cur.tag, ".fwd"}, 32'(fwd_sel), 32'(cur.fwd));
      chk({cur.tag, ".ctl"}, 32'({stall_pc, stall_if_id, bubble_id_ex, stall_ex_mem}), 32'(cur.ctl));
      chk({cur.tag, ".to"}, 32'(timeout_err), 32'(cur.to));
      chk({cur.tag, ".cnt"}, 32'(lu_stall_cnt), 32'(cur.cnt));
    end
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    clear();
    rst_n = 0;
    @(posedge clk);
    #1;
    step("reset", 4'b0000, 4'b0000, 0);
    rst_n = 1;
    mem_rd = 5; mem_reg_write = 1; wb_rd = 5; wb_reg_write = 1; ex_rs = {5'd3, 5'd5};
    step("fwd_mem", 4'b0010, 4'b0000, 0);
    mem_rd = 0;
    step("fwd_wb", 4'b0001, 4'b0000, 0);
    mem_rd = 5; wb_rd = 4; ex_rs = {5'd4, 5'd5};
    step("fwd_mix", 4'b0110, 4'b0000, 0);
    mem_reg_write = 0; wb_rd = 5; ex_rs = {5'd3, 5'd5};
    step("fwd_wb_only", 4'b0001, 4'b0000, 0);
    clear(); mem_reg_write = 1; wb_reg_write = 1;
    step("fwd_rd0", 4'b0000, 4'b0000, 0);
    clear(); id_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_rd = 7; id_rs = {5'd7, 5'd0};
    step("lu", 4'b0000, 4'b1110, 0);
    ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0;
    step("lu_nop", 4'b0000, 4'b0000, 0);
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 0; id_rs = '0;
    step("lu_rd0", 4'b0000, 4'b0000, 0);
    ex_rd = 7; id_rs = {5'd0, 5'd7}; id_valid = 0;
    step("lu_novalid", 4'b0000, 4'b0000, 0);
    id_valid = 1; ex_reg_write = 0;
    step("lu_nowrite", 4'b0000, 4'b0000, 0);
    ex_mem_read = 0; ex_reg_write = 1;
    step("no_load", 4'b0000, 4'b0000, 0);
    ex_mem_read = 1; mem_busy = 1;
    repeat (3) step("frz", 4'b0000, 4'b1101, 0);
    mem_busy = 0;
    step("frz_lu", 4'b0000, 4'b1110, 0);
    clear();
    step("frz_after", 4'b0000, 4'b0000, 0);
    mem_busy = 1;
    for (int k = 1; k <= 16; k++) step(k < 15 ? "busy" : "busy_edge", 4'b0000, 4'b1101, k == 16);
    mem_busy = 0;
    step("to_sticky", 4'b0000, 4'b0000, 1);
    rst_n = 0; #1; rst_n = 1; exp_cnt = 0;
    step("to_clear", 4'b0000, 4'b0000, 0);
    mem_busy = 1;
    repeat (2) step("busy2", 4'b0000, 4'b1101, 0);
    rst_n = 0; mem_busy = 0;
    step("rst_mid", 4'b0000, 4'b0000, 0);
    rst_n = 1;
    step("post_rst", 4'b0000, 4'b0000, 0);
    clear(); wb_rd = 9; wb_reg_write = 1;
    step("bp_load", 4'b0000, 4'b0000, 0);
    wb_rd = 0; wb_reg_write = 0; ex_rs = {5'd9, 5'd0};
`ifdef WB_BYPASS_EN
    step("bp_hit", 4'b1100, 4'b0000, 0);
`else
    step("bp_hit", 4'b0000, 4'b0000, 0);
`endif
    ex_rs = '0; mem_busy = 1; wb_rd = 11; wb_reg_write = 1;
    step("bp_frz", 4'b0000, 4'b1101, 0);
    mem_busy = 0; wb_rd = 0; wb_reg_write = 0; ex_rs = {5'd9, 5'd11};
`ifdef WB_BYPASS_EN
    step("bp_hold", 4'b1100, 4'b0000, 0);
`else
    step("bp_hold", 4'b0000, 4'b0000, 0);
`endif
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Parametrised pipeline hazard controller for the 5-stage core; merges operand forwarding, load-use stall/bubble generation and memory-wait pipeline freeze in one block.
- Sits beside the ID/EX, EX/MEM and MEM/WB registers.
- Drives the ALU operand muxes and the PC / IF/ID / ID/EX / EX/MEM enable and flush controls.
- Keeps a watchdog on memory wait and a saturating load-use stall counter for performance analysis.

Parameters:
REG_ADDR_W, 5, register address width
NUM_SRC, 2, number of source operands per instruction (2 or 3)
WAIT_CNT_W, 4, width of memory-wait watchdog counter; timeout at 2**WAIT_CNT_W-1 consecutive busy cycles
PERF_CNT_W, 16, width of load-use stall counter

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
id_valid  in  1  instruction in ID is valid
id_rs  in  NUM_SRC*REG_ADDR_W  ID-stage source addresses, operand j at [j*REG_ADDR_W +: REG_ADDR_W]
ex_rs  in  NUM_SRC*REG_ADDR_W  ID/EX source addresses, same packing
ex_rd  in  REG_ADDR_W  ID/EX destination
ex_reg_write  in  1  ID/EX writes rd
ex_mem_read  in  1  ID/EX instruction is a load
mem_rd  in  REG_ADDR_W  EX/MEM destination
mem_reg_write  in  1  EX/MEM writes rd
mem_busy  in  1  data memory not ready; pipeline must hold
wb_rd  in  REG_ADDR_W  MEM/WB destination
wb_reg_write  in  1  MEM/WB writes rd
fwd_sel  out  2*NUM_SRC  per-operand mux select, operand j at [2j +: 2]
stall_pc  out  1  hold PC
stall_if_id  out  1  hold IF/ID
bubble_id_ex  out  1  load NOP into ID/EX
stall_ex_mem  out  1  hold ID/EX, EX/MEM, MEM/WB
timeout_err  out  1  sticky memory-wait timeout flag
lu_stall_cnt  out  PERF_CNT_W  saturating load-use stall count

Behaviour:
- fwd_sel (combinational), per operand j, first match wins:
  - 2'b10: mem_reg_write && mem_rd!=0 && mem_rd==ex_rs[j]
  - 2'b01: wb_reg_write && wb_rd!=0 && wb_rd==ex_rs[j]
  - 2'b11: bypass hit (feature only)
  - 2'b00: otherwise
- Load-use hazard lu = id_valid && ex_mem_read && ex_reg_write && ex_rd!=0 && ex_rd==id_rs[j] for any j.
- FSM states RUN, MEM_WAIT; state reset value RUN.
- RUN:
  - mem_busy=1: stall_pc=stall_if_id=stall_ex_mem=1, bubble_id_ex=0; next MEM_WAIT, wait_cnt<=1.
  - else lu=1: stall_pc=stall_if_id=bubble_id_ex=1, stall_ex_mem=0, for exactly that cycle.
  - else all control outputs 0.
- MEM_WAIT:
  - Freeze outputs as above while mem_busy=1; wait_cnt increments, saturating at all-ones.
  - mem_busy=0: return to RUN combinationally in the same cycle (outputs computed as RUN); wait_cnt<=0.
- Freeze has priority over load-use. lu is re-evaluated after the freeze releases (pipe contents unchanged), so one bubble follows.
- Same lu condition never produces two consecutive bubbles: after a bubble, ID/EX holds a NOP.
- timeout_err: set on the cycle wait_cnt reaches all-ones with mem_busy still 1. Stays set until rst_n low. Does not alter stall behaviour.
- lu_stall_cnt: +1 on each cycle bubble_id_ex=1; saturates at all-ones.
- Reset values: state RUN, wait_cnt 0, timeout_err 0, lu_stall_cnt 0, bypass register invalid. Async assert and clear at any point, including mid-MEM_WAIT; outputs then follow RUN with no residual stall.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined:
  - Register bp_rd/bp_valid captures wb_rd when wb_reg_write && wb_rd!=0 && !stall_ex_mem; otherwise holds.
  - Operand hit where bp_valid && bp_rd==ex_rs[j] and no higher-priority match gives 2'b11.
  - Covers the read-after-writeback case for register files without write-through.
- Undefined: encoding 2'b11 is never produced; no bypass register exists.

Test Plan:
- EX/MEM rd=5 reg_write, MEM/WB rd=5 reg_write, ex_rs0=5 -> fwd_sel[1:0]=2'b10; with mem_rd=0 instead -> 2'b01.
- Load in ID/EX ex_rd=7, id_rs1=7, id_valid=1 -> one cycle of stall_pc, stall_if_id and bubble_id_ex; lu_stall_cnt 0->1; next cycle all controls 0.
- ex_rd=0 load with id_rs0=0 -> no stall; rd=0 writes never forward (fwd_sel=0).
- mem_busy held 3 cycles during a load-use hazard -> stall_ex_mem=1 for 3 cycles with bubble_id_ex=0; then exactly one bubble cycle.
- mem_busy held 16 cycles, WAIT_CNT_W=4 -> timeout_err rises on cycle 15 and stays after mem_busy falls; rst_n pulse clears it and returns to RUN.
- WB_BYPASS_EN defined: wb writes rd=9, next cycle ex_rs1=9 with no other match -> fwd_sel[3:2]=2'b11; undefined -> 2'b00.
